// File: rtl/hex_seg_pkg.sv
// Shared decode constants, scan-state encoding and width helper for the
// hex_seg_scanner seven-segment display driver.
package hex_seg_pkg;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_A   = 7'h77;
   localparam logic [6:0] SEG_B   = 7'h7C;
   localparam logic [6:0] SEG_C   = 7'h39;
   localparam logic [6:0] SEG_D   = 7'h5E;
   localparam logic [6:0] SEG_E   = 7'h79;
   localparam logic [6:0] SEG_F   = 7'h71;
   localparam logic [6:0] SEG_OFF = 7'h00;

   // START holds the prescaler for the first edge after reset so the
   // first digit gets a full slot; RUN is normal scanning.
   typedef enum logic {
      SCAN_START = 1'b0,
      SCAN_RUN   = 1'b1
   } scan_state_e;

   // Hex nibble to active-high segment pattern
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] pat;
      case (nibble)
         4'h0:    pat = SEG_0;
         4'h1:    pat = SEG_1;
         4'h2:    pat = SEG_2;
         4'h3:    pat = SEG_3;
         4'h4:    pat = SEG_4;
         4'h5:    pat = SEG_5;
         4'h6:    pat = SEG_6;
         4'h7:    pat = SEG_7;
         4'h8:    pat = SEG_8;
         4'h9:    pat = SEG_9;
         4'hA:    pat = SEG_A;
         4'hB:    pat = SEG_B;
         4'hC:    pat = SEG_C;
         4'hD:    pat = SEG_D;
         4'hE:    pat = SEG_E;
         default: pat = SEG_F;
      endcase
      return pat;
   endfunction

   // Ceiling log2, used for counter and index widths
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      longint unsigned p;
      w = 0;
      p = 1;
      while (p < longint'(n)) begin
         p = p << 1;
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/hex_seg_prescaler.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 while enabled and raises a
// one-cycle tick_c on the terminal count.
module hex_seg_prescaler
   import hex_seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick_c
);

   localparam int unsigned CNT_W = clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count and terminal-count tick
   always_comb begin
      cnt_d  = cnt_q;
      tick_c = 1'b0;
      if (en) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_c = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hex_seg_scanner.sv
// Time-multiplexed N-digit hex seven-segment driver. Latches value/dp_in on
// load, scans one digit per REFRESH_DIV clocks with a one-clock dark gap on
// every digit change. Optional macro HEX_SEG_LEADING_ZERO_BLANK_EN enables
// leading-zero suppression.
module hex_seg_scanner
   import hex_seg_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic                load,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic [DIGITS-1:0]   blank,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   an
);

   localparam int unsigned IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
   localparam int unsigned VAL_W = 4 * DIGITS;
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]        SEG_IDLE = {7{ACTIVE_LOW}};

   scan_state_e        state_q;
   scan_state_e        state_d;
   logic               scan_en_c;
   logic               tick_c;

   logic [VAL_W-1:0]   shadow_q;
   logic [VAL_W-1:0]   shadow_d;
   logic [DIGITS-1:0]  dp_shadow_q;
   logic [DIGITS-1:0]  dp_shadow_d;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_d;
   logic [DIGITS-1:0]  an_q;
   logic [DIGITS-1:0]  an_d;
   logic [6:0]         seg_q;
   logic [6:0]         seg_d;
   logic               dp_q;
   logic               dp_d;

   logic [DIGITS-1:0]  lz_mask;
   logic [DIGITS-1:0]  an_hi;
   logic [6:0]         seg_hi;
   logic               dp_hi;

   // Scan state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SCAN_START;
      end else begin
         state_q <= state_d;
      end
   end

   // Scan next state: leave START after the first edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         SCAN_START: state_d = SCAN_RUN;
         default:    state_d = SCAN_RUN;
      endcase
   end

   // Scan state outputs: prescaler runs only once scanning has started
   always_comb begin
      scan_en_c = 1'b0;
      case (state_q)
         SCAN_RUN: scan_en_c = 1'b1;
         default:  scan_en_c = 1'b0;
      endcase
   end

   hex_seg_prescaler #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (scan_en_c),
      .tick_c  (tick_c)
   );

   // Shadow capture and digit index advance
   always_comb begin
      shadow_d    = shadow_q;
      dp_shadow_d = dp_shadow_q;
      idx_d       = idx_q;
      if (load) begin
         shadow_d    = value;
         dp_shadow_d = dp_in;
      end
      if (tick_c) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

`ifdef HEX_SEG_LEADING_ZERO_BLANK_EN
   // Leading-zero mask: walk down from the top digit while nibbles are zero
   // and no decimal point has been seen; digit 0 is always shown.
   always_comb begin
      logic lz_run;
      lz_run  = 1'b1;
      lz_mask = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         lz_run     = lz_run & (shadow_q[4*i +: 4] == 4'h0) & ~dp_shadow_q[i];
         lz_mask[i] = lz_run;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Output pattern for the next edge; dark on the digit-advance edge
   always_comb begin
      an_hi  = '0;
      seg_hi = SEG_OFF;
      dp_hi  = 1'b0;
      if (!tick_c) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
               an_hi[k] = 1'b1;
               if (!blank[k] && !lz_mask[k]) begin
                  seg_hi = hex_to_seg(shadow_q[4*k +: 4]);
                  dp_hi  = dp_shadow_q[k];
               end
            end
         end
      end
      an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
      seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_d  = ACTIVE_LOW ? ~dp_hi  : dp_hi;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q    <= '0;
         dp_shadow_q <= '0;
         idx_q       <= '0;
         an_q        <= AN_IDLE;
         seg_q       <= SEG_IDLE;
         dp_q        <= ACTIVE_LOW;
      end else begin
         shadow_q    <= shadow_d;
         dp_shadow_q <= dp_shadow_d;
         idx_q       <= idx_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_hex_seg_scanner.sv
// Self-checking bench for hex_seg_scanner: a 4-digit active-low instance and
// a 1-digit active-high instance share stimulus and are compared each clock
// against a slot-arithmetic reference model.
module tb_hex_seg_scanner;

   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [6:0]  seg1;
   logic        dp1;
   logic [0:0]  an1;

   int          total = 0;
   int          bad = 0;

   // Reference model state: shadow copies and edges since reset release
   logic [15:0] m_sh = '0;
   logic [3:0]  m_dp = '0;
   int          m_k = 0;

   always #5 clk = ~clk;

   hex_seg_scanner #(.DIGITS(4), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1)) u_dut (
      .clk (clk), .reset_n (reset_n), .value (value), .load (load),
      .dp_in (dp_in), .blank (blank), .seg (seg), .dp (dp), .an (an)
   );

   hex_seg_scanner #(.DIGITS(1), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b0)) u_dut1 (
      .clk (clk), .reset_n (reset_n), .value (value[3:0]), .load (load),
      .dp_in (dp_in[0:0]), .blank (blank[0:0]), .seg (seg1), .dp (dp1), .an (an1)
   );

   function automatic logic [6:0] dec(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return t[n];
   endfunction

   // Edge k after release: dark when k is a positive multiple of RD,
   // otherwise digit (k/RD) mod nd is enabled.
   function automatic void model(input int nd, input logic run, input int k,
                                 input logic [15:0] sh, input logic [3:0] dps,
                                 input logic [3:0] blk, output logic [3:0] an_hi,
                                 output logic [6:0] seg_hi, output logic dp_hi);
      int   d;
      logic supp;
      an_hi  = '0;
      seg_hi = '0;
      dp_hi  = 1'b0;
      supp   = 1'b0;
      d      = 0;
      if (run && !(k > 0 && (k % RD) == 0)) begin
         d = (k / RD) % nd;
         an_hi[d] = 1'b1;
`ifdef HEX_SEG_LEADING_ZERO_BLANK_EN
         supp = (d != 0) && ((sh >> (4*d)) == 16'h0) && ((dps >> d) == 4'h0);
`endif
         if (!blk[d] && !supp) begin
            seg_hi = dec(sh[4*d +: 4]);
            dp_hi  = dps[d];
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, m_k, obs, exp);
      end
   endtask

   // One clock: predict, clock, compare both instances; ends on negedge
   task automatic cycle();
      logic [3:0] ah, ah1, e_an;
      logic [6:0] sh7, sh1, e_seg;
      logic       dh, dh1, e_dp;
      model(4, reset_n, m_k, m_sh, m_dp, blank, ah, sh7, dh);
      model(1, reset_n, m_k, {12'h0, m_sh[3:0]}, {3'b0, m_dp[0]}, {3'b0, blank[0]},
            ah1, sh1, dh1);
      e_an  = ~ah;
      e_seg = ~sh7;
      e_dp  = ~dh;
      if (reset_n) begin
         if (load) begin
            m_sh = value;
            m_dp = dp_in;
         end
         m_k++;
      end else begin
         m_sh = '0;
         m_dp = '0;
         m_k  = 0;
      end
      @(posedge clk);
      #1;
      chk("an", 16'(an), 16'(e_an));
      chk("seg", 16'(seg), 16'(e_seg));
      chk("dp", 16'(dp), 16'(e_dp));
      chk("an1", 16'(an1), 16'(ah1[0]));
      chk("seg1", 16'(seg1), 16'(sh1));
      chk("dp1", 16'(dp1), 16'(dh1));
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_an"}, 16'(an), 16'h000F);
      chk({tag, "_seg"}, 16'(seg), 16'h007F);
      chk({tag, "_dp"}, 16'(dp), 16'h0001);
      chk({tag, "_seg1"}, 16'(seg1), 16'h0000);
   endtask

   task automatic load_run(input logic [15:0] v, input logic [3:0] dpi, input int n);
      value = v;
      dp_in = dpi;
      load  = 1'b1;
      cycle();
      load  = 1'b0;
      repeat (n) cycle();
   endtask

   initial begin
      logic [3:0] nib;
      logic [6:0] e7;
      int         n;

      // Asynchronous reset assertion with no clock edge
      #1 reset_n = 1'b0;
      #1 chk_idle("rst_async");
      @(negedge clk);
      repeat (3) begin
         value = 16'($urandom);
         load  = 1'($urandom);
         dp_in = 4'($urandom);
         blank = 4'($urandom);
         cycle();
      end
      chk_idle("rst_hold");
      load  = 1'b0;
      blank = '0;
      dp_in = '0;
      reset_n = 1'b1;

      // Scan order with 1234 over two full rotations
      load_run(16'h1234, 4'h0, 2 * 4 * RD + 2);

      // Load FFFF during the digit-2 slot, then change value with load low
      n = 0;
      while (!(((m_k / RD) % 4) == 2 && (m_k % RD) == 1) && n < 64) begin
         cycle();
         n++;
      end
      total++;
      assert (n < 64) else begin
         bad++;
         $error("FAIL wait_digit2 observed=%0d expected=below_64", n);
      end
      value = 16'hFFFF;
      load  = 1'b1;
      cycle();
      load  = 1'b0;
      value = 16'h0000;
      cycle();
      e7 = ~7'h71;
      chk("load_ffff_seg", 16'(seg), 16'(e7));
      chk("load_ffff_an", 16'(an), 16'h000B);
      repeat (8) begin
         value = 16'($urandom);
         cycle();
      end

      // Blank digit 2, decimal point on digit 0
      blank = 4'b0100;
      load_run(16'h1234, 4'b0001, 2 * 4 * RD);
      blank = '0;

      // Reset mid-scan, then restart with a full first slot
      #2 reset_n = 1'b0;
      #1 chk_idle("rst_mid");
      m_sh = '0;
      m_dp = '0;
      m_k  = 0;
      @(negedge clk);
      cycle();
      reset_n = 1'b1;
      load_run(16'hC0DE, 4'h0, 4 * RD + 6);

      // Full decode on every digit slot and on the active-high single digit
      for (int i = 0; i < 16; i++) begin
         nib = 4'(i);
         load_run({4{nib}}, 4'h0, RD + 1);
      end

      // Leading-zero cases (plain display when the feature is off)
      load_run(16'h002A, 4'h0, 2 * 4 * RD);
      load_run(16'h0000, 4'h0, 2 * 4 * RD);
      load_run(16'h0000, 4'b0100, 2 * 4 * RD);
      load_run(16'h0501, 4'h0, 2 * 4 * RD);

      // Randomised traffic, including load held high and live blanking
      for (int i = 0; i < 400; i++) begin
         value = 16'($urandom);
         load  = ($urandom_range(0, 3) == 0) || (i >= 200 && i < 230);
         dp_in = 4'($urandom);
         blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
